// File: rtl/bit_count_unit.sv
// Iterative CLZ / CTZ / CPOP unit scanning CHUNK bits per cycle from the MSB.
// Valid/ready on both sides; flush and async reset abort any operation.
module bit_count_unit #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [XLEN-1:0]        in_operand,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(XLEN):0]  out_result,
  output logic                   busy
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CW     = $clog2(XLEN) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [XLEN-1:0]   work;
  logic [1:0]        op;
  logic [CW-1:0]     count;
  logic [IW-1:0]     idx;
  logic [CHUNK-1:0]  chunk;
  logic              is_cpop;
  logic              last;
  logic              accept;

  function automatic logic [CW-1:0] lead_zeros(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    n = CW'(CHUNK);
    for (int i = 0; i < CHUNK; i++)
      if (c[i]) n = CW'(CHUNK - 1 - i);
    return n;
  endfunction

  function automatic logic [CW-1:0] pop_count(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++)
      if (c[i]) n = n + CW'(1);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++)
      r[i] = v[XLEN-1-i];
    return r;
  endfunction

  assign chunk    = work[XLEN-1 -: CHUNK];
  assign is_cpop  = (op == OP_CPOP);
  assign last     = (idx == LAST) || (!is_cpop && chunk != '0);
  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  assign out_valid  = (state == DONE);
  assign out_result = out_valid ? count : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = BUSY;
      BUSY:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // CTZ is turned into CLZ by reversing the operand at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      op    <= '0;
      count <= '0;
      idx   <= '0;
    end else if (flush) begin
      count <= '0;
      idx   <= '0;
    end else if (accept) begin
      work  <= (in_op == OP_CTZ) ? bit_rev(in_operand) : in_operand;
      op    <= in_op;
      count <= '0;
      idx   <= '0;
    end else if (state == BUSY) begin
      if (is_cpop) begin
        count <= count + pop_count(chunk);
        work  <= work << CHUNK;
        idx   <= idx + IW'(1);
      end else if (chunk != '0) begin
        count <= count + lead_zeros(chunk);
      end else begin
        count <= count + CW'(CHUNK);
        work  <= work << CHUNK;
        idx   <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bit_count_unit.sv
// Scoreboard bench for bit_count_unit: directed vectors, latency,
// back-pressure, flush and async reset aborts.
module tb_bit_count_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_result;
  logic        busy;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   first_seen = 0;

  bit_count_unit #(.XLEN(32), .CHUNK(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples just after the falling edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        if (!first_seen) begin
          check("latency_cycle", cyc, sb[0].cyc);
          first_seen = 1;
        end
        check("result", int'(out_result), sb[0].res);
        check("in_ready_in_done", int'(in_ready), 0);
        if (out_ready) begin
          void'(sb.pop_front());
          first_seen = 0;
        end
      end
    end else begin
      check("result_zero_idle", int'(out_result), 0);
    end
  end

  // Called just after a falling edge; accept happens at the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] v,
                       input int exp, input int k, input bit push);
    in_valid   = 1;
    in_op      = op;
    in_operand = v;
    #1;
    check("in_ready_at_issue", int'(in_ready), 1);
    if (push) sb.push_back('{res: exp, cyc: cyc + k + 1});
    @(posedge clk);
    @(negedge clk);
    in_valid   = 0;
    in_op      = 2'($urandom);
    in_operand = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] v,
                     input int exp, input int k);
    issue(op, v, exp, k, 1);
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 0;
    flush      = 0;
    in_valid   = 1;
    in_op      = 2'b00;
    in_operand = 32'h8000_0000;
    out_ready  = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    flush = 1;
    #1;
    check("reset_flush_in_ready", int'(in_ready), 0);
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;

    run(2'b00, 32'h8000_0000, 0, 1);
    run(2'b00, 32'h0000_0001, 31, 4);
    run(2'b00, 32'h0000_0000, 32, 4);
    run(2'b01, 32'h0000_0100, 8, 2);
    run(2'b01, 32'h0000_0000, 32, 4);
    run(2'b10, 32'hFFFF_FFFF, 32, 4);
    run(2'b10, 32'h0000_0000, 0, 4);
    run(2'b00, 32'h00F0_0000, 8, 2);
    run(2'b00, 32'h0001_0000, 15, 2);
    run(2'b01, 32'h8000_0000, 31, 4);
    run(2'b01, 32'h0000_0006, 1, 1);
    run(2'b11, 32'h0000_1000, 19, 3);
    run(2'b10, 32'h8000_0001, 2, 4);
    run(2'b00, 32'h1234_5678, 3, 1);

    // Back-pressure: 3 cycles of out_ready=0 in DONE.
    out_ready = 0;
    issue(2'b10, 32'h0F0F_0F0F, 16, 4, 1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("stall_valid_seen", int'(out_valid), 1);
    repeat (3) @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    check("stall_released_valid", int'(out_valid), 0);
    check("stall_released_ready", int'(in_ready), 1);
    drain();

    // Flush in the second BUSY cycle.
    issue(2'b00, 32'h0000_0001, 31, 4, 0);
    @(negedge clk);
    flush = 1;
    #1;
    check("flush_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check("flush_busy", int'(busy), 0);
    check("flush_out_valid", int'(out_valid), 0);
    @(negedge clk);
    flush = 0;
    repeat (6) @(negedge clk);
    run(2'b01, 32'h0000_0100, 8, 2);

    // Async reset pulse mid-BUSY.
    issue(2'b10, 32'hFFFF_FFFF, 32, 4, 0);
    #2;
    rst_n = 0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1;
    run(2'b00, 32'h0000_0001, 31, 4);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
